// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Shared defaults, FSM encoding and sizing helper for the data-side store buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

   localparam int unsigned c_DATA_W = 32;
   localparam int unsigned c_ADDR_W = 16;
   localparam int unsigned c_DEPTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_REQ  = 2'd1,
      ST_RD_WAIT = 2'd2
   } state_t;

   // Occupancy counter must represent 0..DEPTH inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_store_buffer_sb_fifo.sv
// ============================================================================
// Module : sb_fifo
// Circular store buffer with optional youngest-match lookup (STORE_FWD_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sb_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = c_DATA_W,
   parameter int unsigned ADDR_W = c_ADDR_W,
   parameter int unsigned DEPTH  = c_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_push_addr,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [ADDR_W-1:0] o_head_addr,
   output logic [DATA_W-1:0] o_head_data,
   output logic              o_empty,
   output logic              o_full
`ifdef STORE_FWD_EN
   ,
   input  logic [ADDR_W-1:0] i_lk_addr,
   output logic              o_lk_hit,
   output logic [DATA_W-1:0] o_lk_data
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_empty     = (r_cnt == '0);
   assign o_full      = (r_cnt == CNT_W'(DEPTH));
   assign w_do_push   = i_push & ~o_full;
   assign w_do_pop    = i_pop & ~o_empty;
   assign o_head_addr = r_addr[r_head];
   assign o_head_data = r_data[r_head];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_do_push) r_tail <= r_tail + PTR_W'(1);
         if (w_do_pop)  r_head <= r_head + PTR_W'(1);
         r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_addr[r_tail] <= i_push_addr;
         r_data[r_tail] <= i_push_data;
      end
   end

`ifdef STORE_FWD_EN
   // Walk oldest to youngest so the last match seen is the youngest.
   always_comb begin
      o_lk_hit  = 1'b0;
      o_lk_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < r_cnt) && (r_addr[r_head + PTR_W'(i)] == i_lk_addr)) begin
            o_lk_hit  = 1'b1;
            o_lk_data = r_data[r_head + PTR_W'(i)];
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_store_buffer.sv
// ============================================================================
// Module : dmem_store_buffer
// Posted-store buffer and load path in front of a shared single-port memory.
// Define STORE_FWD_EN to let loads bypass buffered stores with forwarding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_store_buffer
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = c_DATA_W,
   parameter int unsigned ADDR_W = c_ADDR_W,
   parameter int unsigned DEPTH  = c_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_req_ready,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
   input  logic              i_mem_gnt,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_sb_empty,
   output logic              o_sb_full
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_ld_addr;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic [ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0] w_head_data;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_load_ok;
   logic              w_st_acc;
   logic              w_ld_acc;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_data;
   logic              w_in_wait;

`ifdef STORE_FWD_EN
   logic              w_lk_hit;
   logic [DATA_W-1:0] w_lk_data;

   assign w_load_ok  = 1'b1;
   assign w_fwd_hit  = w_lk_hit;
   assign w_fwd_data = w_lk_data;
`else
   assign w_load_ok  = w_empty;
   assign w_fwd_hit  = 1'b0;
   assign w_fwd_data = '0;
`endif

   sb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_st_acc),
      .i_push_addr (i_req_addr),
      .i_push_data (i_req_wdata),
      .i_pop       (w_pop),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_empty     (w_empty),
      .o_full      (w_full)
`ifdef STORE_FWD_EN
      ,
      .i_lk_addr   (i_req_addr),
      .o_lk_hit    (w_lk_hit),
      .o_lk_data   (w_lk_data)
`endif
   );

   assign o_req_ready = ~rst & (r_state == ST_IDLE) & (i_req_we ? ~w_full : w_load_ok);
   assign w_st_acc    = i_req_valid & o_req_ready & i_req_we;
   assign w_ld_acc    = i_req_valid & o_req_ready & ~i_req_we;
   assign w_in_wait   = ~rst & (r_state == ST_RD_WAIT);

   // Memory read data lands in RD_WAIT and is passed straight to the core.
   assign o_rsp_valid = ~rst & (r_rsp_valid | (r_state == ST_RD_WAIT));
   assign o_rsp_rdata = w_in_wait ? i_mem_rdata : r_rsp_rdata;
   assign o_sb_empty  = w_empty;
   assign o_sb_full   = w_full;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_ld_acc && !w_fwd_hit) w_state_nxt = ST_RD_REQ;
         ST_RD_REQ:  if (i_mem_gnt) w_state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // A waiting load owns the port; otherwise the FIFO head is offered for drain.
   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      w_pop       = 1'b0;
      if (!rst) begin
         if (r_state == ST_RD_REQ) begin
            o_mem_addr = r_ld_addr;
         end else if (!w_empty) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = w_head_addr;
            o_mem_wdata = w_head_data;
            w_pop       = i_mem_gnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ld_addr   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= w_ld_acc & w_fwd_hit;
         if (w_ld_acc) r_ld_addr <= i_req_addr;
         if (w_ld_acc && w_fwd_hit) r_rsp_rdata <= w_fwd_data;
         else if (r_state == ST_RD_WAIT) r_rsp_rdata <= i_mem_rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
// ============================================================================
// Module : tb_dmem_store_buffer
// Directed and random stimulus against a queue-based reference of the store buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_store_buffer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;
`ifdef STORE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              mem_gnt;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              sb_empty;
   logic              sb_full;

   always #5 clk = ~clk;

   dmem_store_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (req_valid),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_rdata (rsp_rdata),
      .i_mem_gnt   (mem_gnt),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_we    (mem_we),
      .i_mem_rdata (mem_rdata),
      .o_sb_empty  (sb_empty),
      .o_sb_full   (sb_full)
   );

   function automatic logic [31:0] init_val(input logic [15:0] a);
      return {16'hA5A5, a};
   endfunction

   // Shared single-port memory with one-cycle read latency.
   logic [31:0] mem [logic [15:0]];
   always @(posedge clk) begin
      if (mem_gnt && mem_we) mem[mem_addr] = mem_wdata;
      if (mem_gnt && !mem_we)
         mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
      else
         mem_rdata <= $urandom();
   end

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } st_t;

   st_t         q[$];
   logic [31:0] ref_mem [logic [15:0]];
   int          mem_phase;    // 0 none, 1 awaiting grant, 2 data returning
   logic [15:0] ld_addr;
   logic        rsp_due;
   logic [31:0] exp_rsp;
   bit          last_acc;
   int          n_assert = 0;
   int          n_fail   = 0;

   function automatic logic [31:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the negedge against the reference, then advance.
   task automatic cycle();
      bit          hit;
      bit          exp_ready;
      bit          nxt_due;
      logic [31:0] hd;
      @(negedge clk);
      last_acc = 1'b0;
      nxt_due  = 1'b0;
      hit      = 1'b0;
      hd       = '0;
      if (rst) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_mem_we",    32'(mem_we),    32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         q.delete();
         mem_phase = 0;
         rsp_due   = 1'b0;
      end else begin
         chk("sb_empty",  32'(sb_empty),  32'(q.size() == 0));
         chk("sb_full",   32'(sb_full),   32'(q.size() == DEPTH));
         chk("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
         if (rsp_due) chk("rsp_rdata", rsp_rdata, exp_rsp);
         exp_ready = (mem_phase == 0) &&
                     (req_we ? (q.size() < DEPTH) : (FWD ? 1'b1 : (q.size() == 0)));
         chk("req_ready", 32'(req_ready), 32'(exp_ready));
         foreach (q[i]) if (q[i].a == req_addr) begin hit = 1'b1; hd = q[i].d; end
         if (mem_phase == 1) begin
            chk("rd_mem_we",   32'(mem_we),   32'd0);
            chk("rd_mem_addr", 32'(mem_addr), 32'(ld_addr));
            if (mem_gnt) begin mem_phase = 2; nxt_due = 1'b1; end
         end else begin
            if (mem_phase == 2) mem_phase = 0;
            if (q.size() > 0) begin
               chk("drain_we",    32'(mem_we),    32'd1);
               chk("drain_addr",  32'(mem_addr),  32'(q[0].a));
               chk("drain_wdata", mem_wdata,      q[0].d);
               if (mem_gnt) begin
                  ref_mem[q[0].a] = q[0].d;
                  void'(q.pop_front());
               end
            end else begin
               chk("idle_mem_we", 32'(mem_we), 32'd0);
            end
         end
         if (req_valid && exp_ready) begin
            last_acc = 1'b1;
            if (req_we) begin
               q.push_back(st_t'{a: req_addr, d: req_wdata});
            end else if (FWD && hit) begin
               nxt_due = 1'b1;
               exp_rsp = hd;
            end else begin
               mem_phase = 1;
               ld_addr   = req_addr;
               exp_rsp   = ref_rd(req_addr);
            end
         end
         rsp_due = nxt_due;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit we, input logic [15:0] a, input logic [31:0] d, input int bound);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      for (int k = 0; k < bound; k++) begin
         cycle();
         if (last_acc) break;
      end
      chk("req_accepted", 32'(last_acc), 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; mem_gnt = 1'b0;
      mem_phase = 0; rsp_due = 1'b0; ld_addr = '0; exp_rsp = '0;
      run(2);
      rst = 1'b0;
      chk("reset_sb_empty",  32'(sb_empty),  32'd1);
      chk("reset_sb_full",   32'(sb_full),   32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata,      32'd0);
      chk("reset_mem_we",    32'(mem_we),    32'd0);
      chk("reset_mem_addr",  32'(mem_addr),  32'd0);
      run(1);

      // Fill to full with the port withheld, then release and drain.
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) do_req(1'b1, 16'h00A0 + 16'(i), 32'h1000 + 32'(i), 2);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h00A4; req_wdata = 32'h1004;
      run(2);
      chk("full_blocks_store", 32'(last_acc), 32'd0);
      chk("full_flag",         32'(sb_full),  32'd1);
      mem_gnt = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (last_acc) break;
      end
      chk("fifth_store_accepted", 32'(last_acc), 32'd1);
      req_valid = 1'b0;
      run(6);

`ifdef STORE_FWD_EN
      mem_gnt = 1'b0;
      do_req(1'b1, 16'h0010, 32'hDEADBEEF, 2);
      do_req(1'b0, 16'h0010, 32'h0, 2);
      chk("fwd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("fwd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      run(1);
      do_req(1'b1, 16'h0020, 32'd1, 2);
      do_req(1'b1, 16'h0020, 32'd2, 2);
      do_req(1'b0, 16'h0020, 32'h0, 2);
      chk("fwd_youngest", rsp_rdata, 32'd2);
      run(1);
      mem_gnt = 1'b1;
      run(6);
      mem_gnt = 1'b0;
      do_req(1'b1, 16'h0048, 32'd7, 2);
      do_req(1'b1, 16'h0049, 32'd8, 2);
`else
      mem_gnt = 1'b1;
      do_req(1'b1, 16'h0030, 32'h55, 2);
      do_req(1'b0, 16'h0030, 32'h0, 10);
      cycle();
      chk("nofwd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("nofwd_rsp_rdata", rsp_rdata, 32'h55);
      run(1);
      mem_gnt = 1'b0;
`endif

      // Load miss held off by the arbiter.
      do_req(1'b0, 16'h0040, 32'h0, 2);
      run(3);
      chk("miss_no_drain", 32'(sb_empty), 32'(!FWD));
      mem_gnt = 1'b1;
      cycle();
      chk("miss_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("miss_rsp_rdata", rsp_rdata, init_val(16'h0040));
      run(6);

      // Reset with stores pending discards them.
      mem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) do_req(1'b1, 16'h0050 + 16'(i), 32'h2000 + 32'(i), 2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_sb_empty",  32'(sb_empty),  32'd1);
      chk("midrst_mem_we",    32'(mem_we),    32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rsp_rdata", rsp_rdata,      32'd0);
      mem_gnt = 1'b1;
      run(4);
      do_req(1'b0, 16'h0050, 32'h0, 4);
      run(3);

      // Random traffic over a small address window to exercise forwarding.
      for (int n = 0; n < 800; n++) begin
         rst       = ($urandom_range(0, 149) == 0);
         req_valid = $urandom_range(0, 1) != 0;
         req_we    = $urandom_range(0, 1) != 0;
         req_addr  = 16'($urandom_range(0, 7));
         req_wdata = $urandom();
         mem_gnt   = $urandom_range(0, 3) != 0;
         cycle();
      end

      rst = 1'b0; req_valid = 1'b0; mem_gnt = 1'b1;
      run(12);
      chk("final_sb_empty", 32'(sb_empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
